// File: rtl/ppu_pkg.sv
// Shared PPU definitions: mode encoding, VRAM window and open-bus value.
// Used by vram_arbiter (optional mode-3 stall behaviour: VRAM_ARB_STALL_EN).
package ppu_pkg;

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_XFER   = 2'd3
    } ppu_mode_t;

    localparam logic [15:0] VRAM_BASE = 16'h8000;
    localparam int          VRAM_AW   = 13;
    localparam logic [7:0]  OPEN_BUS  = 8'hFF;

    // True when a CPU address falls in the 8 KiB VRAM window.
    function automatic logic in_vram(input logic [15:0] a);
        return a[15:13] == VRAM_BASE[15:13];
    endfunction

endpackage

// File: rtl/vram_arbiter.sv
// Shares the single-port VRAM BRAM between the PPU fetcher and the CPU bus.
// Define VRAM_ARB_STALL_EN to stall mode-3 CPU accesses instead of open-bus acking them.
module vram_arbiter
    import ppu_pkg::*;
#(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    ppu_mode,
    input  logic          ppu_req,
    input  logic [AW-1:0] ppu_a,
    output logic          ppu_gnt,
    output logic          ppu_valid,
    output logic [DW-1:0] ppu_dout,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [15:0]   cpu_a,
    input  logic [DW-1:0] cpu_din,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_dout,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CPU_STALL,
        S_CPU_RESP
    } state_t;

    state_t        state_q, state_d;
    logic          ppu_inflight_q;
    logic          cpu_ack_q;
    logic [DW-1:0] ppu_dout_q;
    logic [DW-1:0] cpu_dout_q;
    logic [AW-1:0] ram_a_q;

    logic xfer, cpu_hit, cpu_elig;
    logic cpu_grant, cpu_stall, cpu_openbus, ppu_grant;

    always_comb begin
        xfer     = (ppu_mode_t'(ppu_mode) == MODE_XFER);
        cpu_hit  = in_vram(cpu_a);
        cpu_elig = !rst && cpu_req && (state_q == S_IDLE || state_q == S_CPU_STALL);
`ifdef VRAM_ARB_STALL_EN
        cpu_grant   = cpu_elig && cpu_hit && !xfer;
        cpu_stall   = cpu_elig && cpu_hit && xfer;
        cpu_openbus = cpu_elig && !cpu_hit;
`else
        cpu_grant   = cpu_elig && cpu_hit && !xfer;
        cpu_stall   = 1'b0;
        cpu_openbus = cpu_elig && !(cpu_hit && !xfer);
`endif
        ppu_grant = !rst && ppu_req && !cpu_grant;

        // CPU_RESP always falls back to IDLE: cpu_elig is false there.
        state_d = S_IDLE;
        if (cpu_grant && !cpu_wr)
            state_d = S_CPU_RESP;
        else if (cpu_stall)
            state_d = S_CPU_STALL;
    end

    always_comb begin
        ppu_gnt = ppu_grant;
        ram_we  = cpu_grant && cpu_wr;
        ram_din = cpu_grant ? cpu_din : '0;
        if (rst)
            ram_a = '0;
        else if (cpu_grant)
            ram_a = cpu_a[AW-1:0];
        else if (ppu_grant)
            ram_a = ppu_a;
        else
            ram_a = ram_a_q;
    end

    // Read data comes straight off the BRAM output register in the
    // valid/ack cycle and is held afterwards; rst squashes in-flight responses.
    always_comb begin
        ppu_valid = ppu_inflight_q && !rst;
        cpu_ack   = cpu_ack_q && !rst;
        if (rst) begin
            ppu_dout = '0;
            cpu_dout = '0;
        end else begin
            ppu_dout = ppu_inflight_q ? ram_dout : ppu_dout_q;
            cpu_dout = (state_q == S_CPU_RESP) ? ram_dout : cpu_dout_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            ppu_inflight_q <= 1'b0;
            cpu_ack_q      <= 1'b0;
            ppu_dout_q     <= '0;
            cpu_dout_q     <= '0;
            ram_a_q        <= '0;
        end else begin
            state_q        <= state_d;
            ppu_inflight_q <= ppu_grant;
            cpu_ack_q      <= cpu_grant || cpu_openbus;
            ram_a_q        <= ram_a;
            if (ppu_inflight_q)
                ppu_dout_q <= ram_dout;
            if (state_q == S_CPU_RESP)
                cpu_dout_q <= ram_dout;
            else if (cpu_openbus && !cpu_wr)
                cpu_dout_q <= DW'(OPEN_BUS);
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed plus randomized bench for vram_arbiter with a BRAM model and shadow memory.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ppu_mode;
    logic        ppu_req;
    logic [12:0] ppu_a;
    logic        ppu_gnt, ppu_valid;
    logic [7:0]  ppu_dout;
    logic        cpu_req, cpu_wr;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_din;
    logic        cpu_ack;
    logic [7:0]  cpu_dout;
    logic [12:0] ram_a;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_dout;

    logic        pl_we;
    logic [12:0] pl_a;
    logic [7:0]  pl_d;
    logic [7:0]  mem     [0:8191];
    logic [7:0]  ref_mem [0:8191];

    int total  = 0;
    int passed = 0;

    logic [12:0] exp_last_a, exp_a;
    logic [7:0]  exp_pd, exp_cd;
    logic [1:0]  r_mode;
    logic        r_hit, r_wr, r_creq, r_preq, r_use, r_pg;
    logic [15:0] r_a;
    logic [12:0] r_pa;
    logic [7:0]  r_din;

    always #5 clk = ~clk;

    // BRAM model: one-cycle read latency, preload port used only during reset.
    always @(posedge clk) begin
        if (pl_we)
            mem[pl_a] <= pl_d;
        else if (ram_we)
            mem[ram_a] <= ram_din;
        ram_dout <= mem[ram_a];
    end

    vram_arbiter #(.AW(13), .DW(8)) dut (
        .clk(clk), .rst(rst), .ppu_mode(ppu_mode),
        .ppu_req(ppu_req), .ppu_a(ppu_a), .ppu_gnt(ppu_gnt),
        .ppu_valid(ppu_valid), .ppu_dout(ppu_dout),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_a(cpu_a), .cpu_din(cpu_din),
        .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .ram_a(ram_a), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_set(input logic req, input logic wr, input logic [15:0] a, input logic [7:0] d);
        cpu_req = req;
        cpu_wr  = wr;
        cpu_a   = a;
        cpu_din = d;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ppu_mode = 2'd1; ppu_req = 1'b0; ppu_a = '0;
        cpu_set(1'b0, 1'b0, 16'h0, 8'h0);
        pl_we = 1'b1; pl_a = '0; pl_d = '0;
        for (int i = 0; i < 8192; i++) begin
            pl_a = 13'(i);
            pl_d = 8'($urandom);
            ref_mem[i] = pl_d;
            next();
        end
        pl_we = 1'b0;
        #1;
        chk("rst_ppu_gnt", ppu_gnt, 0);
        chk("rst_ppu_valid", ppu_valid, 0);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ppu_dout", ppu_dout, 0);
        chk("rst_cpu_dout", cpu_dout, 0);
        chk("rst_ram_a", ram_a, 0);
        chk("rst_ram_din", ram_din, 0);
        next();
        rst = 1'b0;
        exp_last_a = '0;

        // Idle CPU write then read-back
        ppu_mode = 2'd1;
        cpu_set(1'b1, 1'b1, 16'h8123, 8'h5A);
        #1;
        chk("wr_ram_we", ram_we, 1);
        chk("wr_ram_a", ram_a, 13'h0123);
        chk("wr_ram_din", ram_din, 8'h5A);
        chk("wr_no_early_ack", cpu_ack, 0);
        ref_mem[13'h0123] = 8'h5A;
        next();
        cpu_req = 1'b0;
        #1;
        chk("wr_ack", cpu_ack, 1);
        next();
        cpu_set(1'b1, 1'b0, 16'h8123, 8'h00);
        #1;
        chk("rd_ram_a", ram_a, 13'h0123);
        chk("rd_ram_we", ram_we, 0);
        next();
        cpu_req = 1'b0;
        #1;
        chk("rd_ack", cpu_ack, 1);
        chk("rd_data", cpu_dout, ref_mem[13'h0123]);
        next();

        // PPU streaming in mode 3
        ppu_mode = 2'd3;
        for (int i = 0; i < 8; i++) begin
            ppu_req = 1'b1;
            ppu_a = 13'(i);
            #1;
            chk("stream_gnt", ppu_gnt, 1);
            chk("stream_valid", ppu_valid, (i > 0));
            if (i > 0) chk("stream_data", ppu_dout, ref_mem[i-1]);
            next();
        end
        ppu_req = 1'b0;
        exp_last_a = 13'd7;
        #1;
        chk("stream_last_valid", ppu_valid, 1);
        chk("stream_last_data", ppu_dout, ref_mem[7]);
        next();
        #1;
        chk("stream_end_valid", ppu_valid, 0);
        next();

`ifdef VRAM_ARB_STALL_EN
        // Mode-3 CPU read stalls until the mode drops
        ppu_mode = 2'd3;
        cpu_set(1'b1, 1'b0, 16'h9800, 8'h00);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_no_ack", cpu_ack, 0);
            chk("stall_no_we", ram_we, 0);
            next();
        end
        ppu_mode = 2'd0;
        #1;
        chk("stall_grant_a", ram_a, 13'h1800);
        exp_last_a = 13'h1800;
        next();
        cpu_req = 1'b0;
        #1;
        chk("stall_ack", cpu_ack, 1);
        chk("stall_data", cpu_dout, ref_mem[13'h1800]);
        next();
`else
        // Mode-3 CPU access acked at once with no BRAM traffic
        ppu_mode = 2'd3;
        cpu_set(1'b1, 1'b1, 16'h8000, 8'h77);
        #1;
        chk("m3wr_no_we", ram_we, 0);
        chk("m3wr_ram_a_hold", ram_a, exp_last_a);
        next();
        cpu_req = 1'b0;
        #1;
        chk("m3wr_ack", cpu_ack, 1);
        next();
        cpu_set(1'b1, 1'b0, 16'h8000, 8'h00);
        #1;
        chk("m3rd_no_we", ram_we, 0);
        next();
        cpu_req = 1'b0;
        #1;
        chk("m3rd_ack", cpu_ack, 1);
        chk("m3rd_openbus", cpu_dout, 8'hFF);
        next();
        ppu_mode = 2'd1;
        cpu_set(1'b1, 1'b0, 16'h8000, 8'h00);
        exp_last_a = 13'h0;
        next();
        cpu_req = 1'b0;
        #1;
        chk("m3wr_discarded", cpu_dout, ref_mem[0]);
        next();
`endif

        // Collision outside mode 3 and out-of-range decode
        ppu_mode = 2'd0;
        cpu_set(1'b1, 1'b0, 16'h8010, 8'h00);
        ppu_req = 1'b1;
        ppu_a = 13'h0020;
        #1;
        chk("coll_ppu_gnt", ppu_gnt, 0);
        chk("coll_ram_a", ram_a, 13'h0010);
        next();
        cpu_req = 1'b0;
        #1;
        chk("coll_ppu_regnt", ppu_gnt, 1);
        chk("coll_ppu_ram_a", ram_a, 13'h0020);
        chk("coll_cpu_ack", cpu_ack, 1);
        chk("coll_cpu_data", cpu_dout, ref_mem[13'h0010]);
        exp_last_a = 13'h0020;
        next();
        ppu_req = 1'b0;
        #1;
        chk("coll_ppu_valid", ppu_valid, 1);
        chk("coll_ppu_data", ppu_dout, ref_mem[13'h0020]);
        next();
        cpu_set(1'b1, 1'b0, 16'hC000, 8'h00);
        #1;
        chk("oor_ram_a_hold", ram_a, exp_last_a);
        chk("oor_no_we", ram_we, 0);
        next();
        cpu_req = 1'b0;
        #1;
        chk("oor_ack", cpu_ack, 1);
        chk("oor_openbus", cpu_dout, 8'hFF);
        next();

        // Reset in the cycle after a CPU read grant
        ppu_mode = 2'd1;
        cpu_set(1'b1, 1'b0, 16'h8040, 8'h00);
        #1;
        chk("rstrd_ram_a", ram_a, 13'h0040);
        next();
        cpu_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstrd_no_ack", cpu_ack, 0);
        chk("rstrd_cpu_dout", cpu_dout, 0);
        chk("rstrd_ppu_valid", ppu_valid, 0);
        chk("rstrd_ppu_dout", ppu_dout, 0);
        chk("rstrd_ram_a", ram_a, 0);
        chk("rstrd_ram_we", ram_we, 0);
        chk("rstrd_ram_din", ram_din, 0);
        chk("rstrd_ppu_gnt", ppu_gnt, 0);
        next();
        rst = 1'b0;
        #1;
        chk("rstrd_no_late_ack", cpu_ack, 0);
        next();
        cpu_set(1'b1, 1'b0, 16'h8040, 8'h00);
        next();
        cpu_req = 1'b0;
        #1;
        chk("rstrd_retry_ack", cpu_ack, 1);
        chk("rstrd_retry_data", cpu_dout, ref_mem[13'h0040]);
        exp_last_a = 13'h0040;
        next();

        // Randomized single transactions against the shadow memory
        for (int n = 0; n < 300; n++) begin
            r_mode = 2'($urandom_range(0, 3));
            r_hit  = ($urandom_range(0, 3) != 0);
            r_a    = 16'($urandom);
            if (r_hit)
                r_a[15:13] = 3'b100;
            else if (r_a[15:13] == 3'b100)
                r_a[15:13] = 3'b110;
`ifdef VRAM_ARB_STALL_EN
            if (r_hit && r_mode == 2'd3) r_mode = 2'($urandom_range(0, 2));
`endif
            r_wr   = 1'($urandom_range(0, 1));
            r_din  = 8'($urandom);
            r_creq = ($urandom_range(0, 3) != 0);
            r_preq = 1'($urandom_range(0, 1));
            r_pa   = 13'($urandom);

            ppu_mode = r_mode;
            ppu_req  = r_preq;
            ppu_a    = r_pa;
            cpu_set(r_creq, r_wr, r_a, r_din);
            #1;
            r_use = r_creq && r_hit && (r_mode != 2'd3);
            r_pg  = r_preq && !r_use;
            exp_a = r_use ? r_a[12:0] : (r_pg ? r_pa : exp_last_a);
            chk("rnd_ppu_gnt", ppu_gnt, r_pg);
            chk("rnd_ram_we", ram_we, r_use && r_wr);
            chk("rnd_ram_a", ram_a, exp_a);
            exp_last_a = exp_a;
            exp_pd = ref_mem[r_pa];
            exp_cd = r_use ? ref_mem[r_a[12:0]] : 8'hFF;
            if (r_use && r_wr) ref_mem[r_a[12:0]] = r_din;
            next();
            cpu_req = 1'b0;
            ppu_req = 1'b0;
            #1;
            chk("rnd_cpu_ack", cpu_ack, r_creq);
            if (r_creq && !r_wr) chk("rnd_cpu_dout", cpu_dout, exp_cd);
            chk("rnd_ppu_valid", ppu_valid, r_pg);
            if (r_pg) chk("rnd_ppu_dout", ppu_dout, exp_pd);
            next();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
